// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_t;

  localparam int HALT_REG_DEFAULT     = 17;
  localparam int DRAIN_CYCLES_DEFAULT = 3;
  localparam int CNT_W_DEFAULT        = 32;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// rtl/pipeline_hazard_controller_hazard_detect.sv - combinational load-use and ecall-operand hazard detection
module pipeline_hazard_controller_hazard_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int HALT_REG = HALT_REG_DEFAULT
) (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_is_ecall,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic       load_use,
  output logic       ecall_haz
);

  localparam logic [4:0] HREG = 5'(HALT_REG);

  // x0 is never a real producer, so a load targeting it cannot create a dependency
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign ecall_haz = id_is_ecall &&
                     ((ex_reg_write  && (ex_rd  == HREG)) ||
                      (mem_reg_write && (mem_rd == HREG)) ||
                      (wb_reg_write  && (wb_rd  == HREG)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - RV32I pipeline stall/flush/halt sequencer with saturating perf counters
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int HALT_REG     = HALT_REG_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_ecall,
  input  logic             id_halt_cond,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t    state;
  logic [DCW-1:0] drain_cnt;
  logic           load_use;
  logic           ecall_haz;
  logic           stall_ev;
  logic           flush_ev;
  logic           halt_go;

  pipeline_hazard_controller_hazard_detect #(.HALT_REG(HALT_REG)) u_hazard_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_is_ecall   (id_is_ecall),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .load_use      (load_use),
    .ecall_haz     (ecall_haz)
  );

  // Defaults are the frozen/bubbling outputs used in reset, DRAIN and HALTED
  always_comb begin
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    halt_go     = 1'b0;
    if (reset && (state == ST_RUN)) begin
      if (ex_branch_taken) begin
        pc_src      = 1'b1;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        flush_ev    = 1'b1;
      end else if (load_use || ecall_haz) begin
        if_id_flush = 1'b0;
        stall_ev    = 1'b1;
      end else if (id_is_ecall && id_halt_cond) begin
        if_id_write = 1'b1;
        id_ex_flush = 1'b0;
        halt_go     = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      is_halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_go) begin
            state     <= ST_DRAIN;
            drain_cnt <= DCW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= ST_HALTED;
            is_halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // Counters saturate so a long-running program never reports a wrapped small value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_ev && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_ev && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, id_is_ecall, id_halt_cond;
  logic        ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write, ex_branch_taken;
  logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, is_halted;
  logic [31:0] stall_count, flush_count;
  logic        pc_write4, pc_src4, if_id_write4, if_id_flush4, id_ex_flush4, is_halted4;
  logic [3:0]  stall_count4, flush_count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_ecall(id_is_ecall), .id_halt_cond(id_halt_cond),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .is_halted(is_halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_ecall(id_is_ecall), .id_halt_cond(id_halt_cond),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write4), .pc_src(pc_src4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
    .id_ex_flush(id_ex_flush4), .is_halted(is_halted4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_is_ecall = 1'b0; id_halt_cond = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
  endtask

  task automatic check_frozen(input string tag);
    check({tag, "_pc_write"},    32'(pc_write),    32'd0);
    check({tag, "_if_id_write"}, 32'(if_id_write), 32'd0);
    check({tag, "_if_id_flush"}, 32'(if_id_flush), 32'd1);
    check({tag, "_id_ex_flush"}, 32'(id_ex_flush), 32'd1);
    check({tag, "_pc_src"},      32'(pc_src),      32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    #3;
    reset = 1'b1;
    step();
  endtask

  initial begin
    idle_inputs();
    #2;
    check_frozen("rst");
    check("rst_halted", 32'(is_halted), 32'd0);
    check("rst_stall", stall_count, 32'd0);
    check("rst_flush", flush_count, 32'd0);
    step();
    reset = 1'b1;
    step();

    // idle fetch
    check("idle_pc_write", 32'(pc_write), 32'd1);
    check("idle_if_id_write", 32'(if_id_write), 32'd1);
    check("idle_flushes", 32'({if_id_flush, id_ex_flush, pc_src}), 32'd0);

    // lw x5 in EX, add x6,x5,x1 in ID
    set_load_use();
    #1;
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_if_id_write", 32'(if_id_write), 32'd0);
    check("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    check("lu_if_id_flush", 32'(if_id_flush), 32'd0);
    step();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    check("lu_resume_pc_write", 32'(pc_write), 32'd1);
    check("lu_stall_count", stall_count, 32'd1);

    // load to x0, ID reads x0
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
    #1;
    check("x0_pc_write", 32'(pc_write), 32'd1);
    step();
    check("x0_stall_count", stall_count, 32'd1);

    // rs2-only dependence also stalls
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_use_rs2 = 1'b1; id_rs2 = 5'd9; id_rs1 = 5'd9;
    #1;
    check("rs2_pc_write", 32'(pc_write), 32'd0);
    step();
    check("rs2_stall_count", stall_count, 32'd2);

    // branch taken wins over load-use
    idle_inputs();
    set_load_use();
    ex_branch_taken = 1'b1;
    #1;
    check("br_pc_src", 32'(pc_src), 32'd1);
    check("br_pc_write", 32'(pc_write), 32'd1);
    check("br_flushes", 32'({if_id_flush, id_ex_flush}), 32'd3);
    step();
    check("br_flush_count", flush_count, 32'd1);
    check("br_stall_count", stall_count, 32'd2);

    // ex rd==17 without ecall: no stall; ecall without halt cond: pass-through
    idle_inputs();
    ex_reg_write = 1'b1; ex_rd = 5'd17;
    #1;
    check("noecall_pc_write", 32'(pc_write), 32'd1);
    idle_inputs();
    id_is_ecall = 1'b1;
    #1;
    check("ecall_nohalt_pc_write", 32'(pc_write), 32'd1);
    check("ecall_nohalt_id_ex_flush", 32'(id_ex_flush), 32'd0);
    step();

    // ecall waits on x17 producer in MEM then WB
    idle_inputs();
    id_is_ecall = 1'b1; id_halt_cond = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd17;
    #1;
    check("ecall_haz_pc_write", 32'(pc_write), 32'd0);
    check("ecall_haz_id_ex_flush", 32'(id_ex_flush), 32'd1);
    step();
    mem_reg_write = 1'b0; wb_reg_write = 1'b1; wb_rd = 5'd17;
    #1;
    check("ecall_haz_wb_pc_write", 32'(pc_write), 32'd0);
    step();
    check("ecall_haz_stall_count", stall_count, 32'd4);
    wb_reg_write = 1'b0;
    #1;
    check("ecall_go_pc_write", 32'(pc_write), 32'd0);
    check("ecall_go_if_id_flush", 32'(if_id_flush), 32'd1);
    check("ecall_go_id_ex_flush", 32'(id_ex_flush), 32'd0);
    step();
    idle_inputs();
    ex_branch_taken = 1'b1;
    #1;
    check_frozen("drain1");
    check("drain1_halted", 32'(is_halted), 32'd0);
    step();
    check("drain2_halted", 32'(is_halted), 32'd0);
    check("drain2_pc_write", 32'(pc_write), 32'd0);
    step();
    check("drain3_halted", 32'(is_halted), 32'd0);
    check("drain3_pc_write", 32'(pc_write), 32'd0);
    step();
    check("halt_is_halted", 32'(is_halted), 32'd1);
    check_frozen("halted");
    set_load_use();
    step();
    check("halted_is_halted", 32'(is_halted), 32'd1);
    check("halted_flush_count", flush_count, 32'd1);
    check("halted_stall_count", stall_count, 32'd4);

    // async reset while in DRAIN
    do_reset();
    id_is_ecall = 1'b1; id_halt_cond = 1'b1;
    step();
    idle_inputs();
    step();
    #2;
    reset = 1'b0;
    #1;
    check_frozen("arst");
    check("arst_halted", 32'(is_halted), 32'd0);
    check("arst_stall", stall_count, 32'd0);
    #3;
    reset = 1'b1;
    step();
    check("arst_resume_pc_write", 32'(pc_write), 32'd1);
    check("arst_resume_if_id_write", 32'(if_id_write), 32'd1);
    step();
    check("arst_resume_halted", 32'(is_halted), 32'd0);

    // saturation with 20 consecutive load-use stalls
    do_reset();
    set_load_use();
    for (int i = 0; i < 20; i++) step();
    check("sat_stall_count4", 32'(stall_count4), 32'd15);
    check("sat_stall_count32", stall_count, 32'd20);
    idle_inputs();
    step();
    check("sat_hold_count4", 32'(stall_count4), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
